// File: rtl/flash_prog_pkg.sv
// ============================================================================
// flash_prog_pkg : shared constants, state encoding and helpers for the
//                  serial flash programming engine (FLASH_PROG_VERIFY_EN
//                  adds the read-back state). Rev 1.0
// ============================================================================
`default_nettype none

package flash_prog_pkg;

  localparam logic [7:0] C_SYNC_BYTE = 8'hA5;

  localparam logic [7:0] C_CMD_ERASE = 8'h01;
  localparam logic [7:0] C_CMD_WRITE = 8'h02;

  localparam logic [7:0] C_STAT_OK      = 8'h00;
  localparam logic [7:0] C_STAT_CSUM    = 8'hE1;
  localparam logic [7:0] C_STAT_BADCMD  = 8'hE2;
  localparam logic [7:0] C_STAT_VERIFY  = 8'hE3;
  localparam logic [7:0] C_STAT_TIMEOUT = 8'hE4;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_HDR,
    ST_CMD,
    ST_ADDR,
    ST_LEN,
    ST_DLO,
    ST_DHI,
    ST_FWR,
`ifdef FLASH_PROG_VERIFY_EN
    ST_VFY,
`endif
    ST_CSUM,
    ST_FER,
    ST_RESP
  } state_t;

  // States in which the engine is ready to consume a receive byte.
  function automatic logic takes_byte(input state_t s);
    return s inside {ST_IDLE, ST_HDR, ST_CMD, ST_ADDR, ST_LEN, ST_DLO, ST_DHI, ST_CSUM};
  endfunction

  // The first error of a frame sticks; later ones are dropped.
  function automatic logic [7:0] latch_err(input logic [7:0] cur, input logic [7:0] err);
    return (cur == C_STAT_OK) ? err : cur;
  endfunction

endpackage

`default_nettype wire

// File: rtl/flash_prog_timeout.sv
// ============================================================================
// flash_prog_timeout : loadable down-counter; clear reloads, run counts down,
//                      expired pulses for one cycle when the budget runs out.
//                      Rev 1.0
// ============================================================================
`default_nettype none

module flash_prog_timeout #(
  parameter int TIMEOUT_CYCLES = 5_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic run,
  output logic expired
);

  localparam int               CNT_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] C_LOAD = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] count_q, count_d;

  // Loaded with N-1 so that the N-th consecutive run cycle fires.
  always_comb begin
    count_d = count_q;
    expired = 1'b0;
    if (clear) begin
      count_d = C_LOAD;
    end else if (run) begin
      if (count_q == '0) begin
        expired = 1'b1;
        count_d = C_LOAD;
      end else begin
        count_d = count_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= C_LOAD;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/flash_programmer.sv
// ============================================================================
// flash_programmer : parses erase/write command frames from the UART receive
//                   path, drives flash_io requests and returns a status byte.
//                   Optional read-back verify under FLASH_PROG_VERIFY_EN.
//                   Rev 1.0
// ============================================================================
`default_nettype none

module flash_programmer
  import flash_prog_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 5_000_000,
  parameter int ADDR_W         = 22
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic [ADDR_W-1:0] flash_addr,
  output logic [15:0]       flash_wdata,
  output logic              flash_write,
  output logic              flash_erase,
  output logic              flash_read,
  input  logic [15:0]       flash_rdata,
  input  logic              flash_ack,
  output logic              busy
);

  state_t            state_q, state_d;
  logic [7:0]        cmd_q, cmd_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       cnt_q, cnt_d;
  logic [1:0]        byte_cnt_q, byte_cnt_d;
  logic [7:0]        csum_q, csum_d;
  logic [7:0]        status_q, status_d;
  logic [15:0]       wdata_q, wdata_d;
  logic              write_q, write_d;
  logic              erase_q, erase_d;
  logic              tx_valid_q, tx_valid_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic              rx_ready_q, rx_ready_d;

  logic              rx_fire;
  logic              wait_byte;
  logic              to_clear;
  logic              to_run;
  logic              to_expired;
  logic [15:0]       len_word;

  assign rx_fire   = rx_valid && rx_ready_q;
  assign wait_byte = takes_byte(state_q) && (state_q != ST_IDLE);
  assign to_clear  = !wait_byte || rx_fire;
  assign to_run    = wait_byte && !rx_valid;
  assign len_word  = {cnt_q[7:0], rx_data};

  flash_prog_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .clear  (to_clear),
    .run    (to_run),
    .expired(to_expired)
  );

`ifdef FLASH_PROG_VERIFY_EN
  logic rd_q, rd_d;
`endif

  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    addr_d     = addr_q;
    cnt_d      = cnt_q;
    byte_cnt_d = byte_cnt_q;
    csum_d     = csum_q;
    status_d   = status_q;
    wdata_d    = wdata_q;

    case (state_q)
      ST_IDLE: begin
        if (rx_fire && rx_data == C_SYNC_BYTE) begin
          state_d  = ST_HDR;
          status_d = C_STAT_OK;
          csum_d   = 8'h00;
        end
      end
      ST_HDR: begin
        if (rx_fire) begin
          cmd_d   = rx_data;
          csum_d  = csum_q ^ rx_data;
          state_d = ST_CMD;
        end
      end
      // CMD takes the top address byte; ADDR collects the remaining two.
      ST_CMD: begin
        if (rx_fire) begin
          addr_d     = ADDR_W'({addr_q, rx_data});
          csum_d     = csum_q ^ rx_data;
          byte_cnt_d = 2'd1;
          state_d    = ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (rx_fire) begin
          addr_d = ADDR_W'({addr_q, rx_data});
          csum_d = csum_q ^ rx_data;
          if (byte_cnt_q == 2'd2) begin
            byte_cnt_d = 2'd0;
            state_d    = ST_LEN;
          end else begin
            byte_cnt_d = byte_cnt_q + 2'd1;
          end
        end
      end
      ST_LEN: begin
        if (rx_fire) begin
          cnt_d  = len_word;
          csum_d = csum_q ^ rx_data;
          if (byte_cnt_q == 2'd0) begin
            byte_cnt_d = 2'd1;
          end else begin
            byte_cnt_d = 2'd0;
            if (cmd_q == C_CMD_WRITE && len_word != 16'd0) begin
              state_d = ST_DLO;
            end else if (cmd_q == C_CMD_WRITE || cmd_q == C_CMD_ERASE) begin
              state_d = ST_CSUM;
            end else begin
              status_d = latch_err(status_q, C_STAT_BADCMD);
              state_d  = ST_CSUM;
            end
          end
        end
      end
      ST_DLO: begin
        if (rx_fire) begin
          wdata_d[7:0] = rx_data;
          csum_d       = csum_q ^ rx_data;
          state_d      = ST_DHI;
        end
      end
      ST_DHI: begin
        if (rx_fire) begin
          wdata_d[15:8] = rx_data;
          csum_d        = csum_q ^ rx_data;
          state_d       = ST_FWR;
        end
      end
      ST_FWR: begin
        if (flash_ack) begin
          cnt_d = cnt_q - 16'd1;
`ifdef FLASH_PROG_VERIFY_EN
          // Address advances only after the read-back of this word.
          state_d = ST_VFY;
`else
          addr_d  = addr_q + ADDR_W'(1);
          state_d = (cnt_q == 16'd1) ? ST_CSUM : ST_DLO;
`endif
        end
      end
`ifdef FLASH_PROG_VERIFY_EN
      ST_VFY: begin
        if (flash_ack) begin
          if (flash_rdata != wdata_q) begin
            status_d = latch_err(status_q, C_STAT_VERIFY);
          end
          addr_d  = addr_q + ADDR_W'(1);
          state_d = (cnt_q == 16'd0) ? ST_CSUM : ST_DLO;
        end
      end
`endif
      ST_CSUM: begin
        if (rx_fire) begin
          if (rx_data != csum_q) begin
            status_d = latch_err(status_q, C_STAT_CSUM);
            state_d  = ST_RESP;
          end else if (cmd_q == C_CMD_ERASE) begin
            state_d = ST_FER;
          end else begin
            state_d = ST_RESP;
          end
        end
      end
      ST_FER: begin
        if (flash_ack) begin
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (tx_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Expiry can only fire while no byte is offered, so a late byte always wins.
    if (to_expired) begin
      status_d = latch_err(status_q, C_STAT_TIMEOUT);
      state_d  = ST_RESP;
    end
  end

  // Registered strobes follow the next state, so they drop the edge after ack.
  always_comb begin
    write_d    = (state_d == ST_FWR);
    erase_d    = (state_d == ST_FER);
    tx_valid_d = (state_d == ST_RESP);
    tx_data_d  = (state_d == ST_RESP) ? status_d : tx_data_q;
    rx_ready_d = takes_byte(state_d);
`ifdef FLASH_PROG_VERIFY_EN
    rd_d       = (state_d == ST_VFY);
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cmd_q      <= 8'h00;
      addr_q     <= '0;
      cnt_q      <= 16'd0;
      byte_cnt_q <= 2'd0;
      csum_q     <= 8'h00;
      status_q   <= C_STAT_OK;
      wdata_q    <= 16'd0;
      write_q    <= 1'b0;
      erase_q    <= 1'b0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= 8'h00;
      rx_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cmd_q      <= cmd_d;
      addr_q     <= addr_d;
      cnt_q      <= cnt_d;
      byte_cnt_q <= byte_cnt_d;
      csum_q     <= csum_d;
      status_q   <= status_d;
      wdata_q    <= wdata_d;
      write_q    <= write_d;
      erase_q    <= erase_d;
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
      rx_ready_q <= rx_ready_d;
    end
  end

`ifdef FLASH_PROG_VERIFY_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q <= 1'b0;
    end else begin
      rd_q <= rd_d;
    end
  end
  assign flash_read = rd_q;
`else
  logic unused_rdata;
  assign unused_rdata = ^flash_rdata;
  assign flash_read   = 1'b0;
`endif

  assign rx_ready    = rx_ready_q;
  assign tx_data     = tx_data_q;
  assign tx_valid    = tx_valid_q;
  assign flash_addr  = addr_q;
  assign flash_wdata = wdata_q;
  assign flash_write = write_q;
  assign flash_erase = erase_q;
  assign busy        = (state_q != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_flash_programmer.sv
// ============================================================================
// tb_flash_programmer : directed frames against a small flash_io model.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_flash_programmer;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [21:0] flash_addr;
  logic [15:0] flash_wdata;
  logic        flash_write;
  logic        flash_erase;
  logic        flash_read;
  logic [15:0] flash_rdata;
  logic        flash_ack;
  logic        busy;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  flash_programmer #(
    .TIMEOUT_CYCLES(100),
    .ADDR_W        (22)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .flash_addr (flash_addr),
    .flash_wdata(flash_wdata),
    .flash_write(flash_write),
    .flash_erase(flash_erase),
    .flash_read (flash_read),
    .flash_rdata(flash_rdata),
    .flash_ack  (flash_ack),
    .busy       (busy)
  );

  // flash_io model: ack three cycles after a request is first seen.
  int          lat = 0;
  int          n_erase = 0;
  int          n_read = 0;
  int          corrupt_idx = -1;
  logic [21:0] erase_addr = '0;
  logic [15:0] mem [int];
  logic [21:0] waddr_log [$];
  logic [15:0] wdata_log [$];

  always @(posedge clk) begin
    if (rst) begin
      flash_ack <= 1'b0;
      lat       <= 0;
    end else if ((flash_write || flash_erase || flash_read) && !flash_ack) begin
      if (lat == 2) begin
        flash_ack <= 1'b1;
        lat       <= 0;
        if (flash_write) begin
          mem[int'(flash_addr)] = flash_wdata;
          waddr_log.push_back(flash_addr);
          wdata_log.push_back(flash_wdata);
        end
        if (flash_erase) begin
          n_erase    <= n_erase + 1;
          erase_addr <= flash_addr;
        end
        if (flash_read) begin
          flash_rdata <= (mem.exists(int'(flash_addr)) ? mem[int'(flash_addr)] : 16'hFFFF)
                         ^ ((n_read == corrupt_idx) ? 16'h0100 : 16'h0000);
          n_read      <= n_read + 1;
        end
      end else begin
        lat <= lat + 1;
      end
    end else begin
      flash_ack <= 1'b0;
      lat       <= 0;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    @(negedge clk);
    while (!rx_ready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (!rx_ready) check_eq("rx_ready_wait", 32'(rx_ready), 32'd1);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  logic [15:0] wbuf [4];

  task automatic send_frame(input logic [7:0] cmd, input logic [23:0] addr,
                            input logic [15:0] len, input int nwords, input logic bad);
    logic [7:0] x;
    send_byte(8'hA5);
    x = cmd ^ addr[23:16] ^ addr[15:8] ^ addr[7:0] ^ len[15:8] ^ len[7:0];
    send_byte(cmd);
    send_byte(addr[23:16]);
    send_byte(addr[15:8]);
    send_byte(addr[7:0]);
    send_byte(len[15:8]);
    send_byte(len[7:0]);
    for (int i = 0; i < nwords; i++) begin
      send_byte(wbuf[i][7:0]);
      send_byte(wbuf[i][15:8]);
      x = x ^ wbuf[i][7:0] ^ wbuf[i][15:8];
    end
    send_byte(bad ? ~x : x);
  endtask

  // Status may already be visible on return from send_byte, so look first.
  task automatic expect_status(input string tag, input logic [7:0] exp, output int waited);
    int n = 0;
    while (!tx_valid && n < 2000) begin
      @(negedge clk);
      n++;
    end
    waited = n;
    if (!tx_valid) check_eq({tag, "_no_resp"}, 32'(tx_valid), 32'd1);
    else           check_eq(tag, 32'(tx_data), 32'(exp));
    @(negedge clk);
  endtask

  initial begin
    int wb, eb, rb, w;
    rst      = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    tx_ready = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("rst_strobes", 32'({rx_ready, tx_valid, flash_write, flash_erase, flash_read, busy}), 32'd0);
    check_eq("rst_tx_data", 32'(tx_data), 32'd0);
    check_eq("rst_addr", 32'(flash_addr), 32'd0);
    check_eq("rst_wdata", 32'(flash_wdata), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check_eq("idle_rx_ready", 32'(rx_ready), 32'd1);
    check_eq("idle_busy", 32'(busy), 32'd0);

    // Noise byte then WRITE 0x000010, two words
    send_byte(8'h33);
    check_eq("noise_busy", 32'(busy), 32'd0);
    wb = waddr_log.size();
    wbuf[0] = 16'h1234;
    wbuf[1] = 16'hABCD;
    send_frame(8'h02, 24'h000010, 16'd2, 2, 1'b0);
    expect_status("wr_status", 8'h00, w);
    check_eq("wr_count", 32'(waddr_log.size() - wb), 32'd2);
    check_eq("wr0_addr", 32'(waddr_log[wb]), 32'h10);
    check_eq("wr0_data", 32'(wdata_log[wb]), 32'h1234);
    check_eq("wr1_addr", 32'(waddr_log[wb+1]), 32'h11);
    check_eq("wr1_data", 32'(wdata_log[wb+1]), 32'hABCD);
    check_eq("wr_idle", 32'(busy), 32'd0);

    // ERASE 0x020000 with bad checksum, then with a good one
    eb = n_erase;
    send_frame(8'h01, 24'h020000, 16'd0, 0, 1'b1);
    expect_status("er_bad_status", 8'hE1, w);
    check_eq("er_bad_count", 32'(n_erase - eb), 32'd0);
    send_frame(8'h01, 24'h020000, 16'd5, 0, 1'b0);
    expect_status("er_ok_status", 8'h00, w);
    check_eq("er_ok_count", 32'(n_erase - eb), 32'd1);
    check_eq("er_ok_addr", 32'(erase_addr), 32'h020000);

    // Unknown command
    wb = waddr_log.size();
    eb = n_erase;
    send_frame(8'h07, 24'h000040, 16'd0, 0, 1'b0);
    expect_status("badcmd_status", 8'hE2, w);
    check_eq("badcmd_flash", 32'((waddr_log.size() - wb) + (n_erase - eb)), 32'd0);

    // Address wrap; bits 23:22 of 0xFFFFFF ignored
    wb = waddr_log.size();
    wbuf[0] = 16'hBEEF;
    wbuf[1] = 16'hCAFE;
    send_frame(8'h02, 24'hFFFFFF, 16'd2, 2, 1'b0);
    expect_status("wrap_status", 8'h00, w);
    check_eq("wrap_count", 32'(waddr_log.size() - wb), 32'd2);
    check_eq("wrap0_addr", 32'(waddr_log[wb]), 32'h3FFFFF);
    check_eq("wrap1_addr", 32'(waddr_log[wb+1]), 32'h000000);
    check_eq("wrap1_data", 32'(wdata_log[wb+1]), 32'hCAFE);

    // Stall after ADDR bytes
    wb = waddr_log.size();
    send_byte(8'hA5);
    send_byte(8'h02);
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h00);
    expect_status("to_status", 8'hE4, w);
    check_eq("to_latency_ok", 32'(w >= 98 && w <= 102), 32'd1);
    check_eq("to_no_write", 32'(waddr_log.size() - wb), 32'd0);

    // Read-back verify with word 1 corrupted by the model
    wb = waddr_log.size();
    rb = n_read;
    corrupt_idx = n_read + 1;
    wbuf[0] = 16'h1111;
    wbuf[1] = 16'h2222;
    send_frame(8'h02, 24'h000100, 16'd2, 2, 1'b0);
`ifdef FLASH_PROG_VERIFY_EN
    expect_status("vfy_status", 8'hE3, w);
    check_eq("vfy_reads", 32'(n_read - rb), 32'd2);
`else
    expect_status("vfy_status", 8'h00, w);
    check_eq("vfy_reads", 32'(n_read - rb), 32'd0);
`endif
    corrupt_idx = -1;
    check_eq("vfy_writes", 32'(waddr_log.size() - wb), 32'd2);
    check_eq("vfy1_addr", 32'(waddr_log[wb+1]), 32'h101);

    // Reset while a write request is outstanding
    wb = waddr_log.size();
    send_byte(8'hA5);
    send_byte(8'h02);
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h40);
    send_byte(8'h00);
    send_byte(8'h01);
    send_byte(8'h77);
    send_byte(8'h66);
    begin
      int n = 0;
      while (!flash_write && n < 50) begin
        @(negedge clk);
        n++;
      end
    end
    check_eq("mid_write_seen", 32'(flash_write), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check_eq("mid_rst_write", 32'(flash_write), 32'd0);
    check_eq("mid_rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    check_eq("mid_rst_nolog", 32'(waddr_log.size() - wb), 32'd0);
    wbuf[0] = 16'h5555;
    send_frame(8'h02, 24'h000020, 16'd1, 1, 1'b0);
    expect_status("post_rst_status", 8'h00, w);
    check_eq("post_rst_count", 32'(waddr_log.size() - wb), 32'd1);
    check_eq("post_rst_addr", 32'(waddr_log[wb]), 32'h20);
    check_eq("post_rst_data", 32'(wdata_log[wb]), 32'h5555);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire

// File: doc/flash_programmer.md
# flash_programmer

Serial-to-flash programming engine: parses command frames arriving from the `uart` receive path, then issues block-erase and word-write requests to `flash_io` through its `data_in`/`ctl_write`/`ctl_erase` port, and returns a one-byte status over the `uart` transmit path. It is the write-direction counterpart of the `mem_bridge` flash read path. It sits beside `mem_bridge`, and `top` muxes the `flash_io` control inputs while `busy` is high.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 5_000_000: idle cycles allowed between bytes of one frame before it is aborted.
- `ADDR_W`, default 22: flash word-address width, matching `flash_io` addr[22:1].

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  reset: synchronous, active-high.
- `rx_data`  in  8  received byte.
- `rx_valid`  in  1  `rx_data` is valid; consumed when `rx_valid && rx_ready`.
- `rx_ready`  out  1  engine accepts a byte this cycle.
- `tx_data`  out  8  status byte.
- `tx_valid`  out  1  `tx_data` is valid; held until `tx_ready`.
- `tx_ready`  in  1  transmitter accepts the status byte.
- `flash_addr`  out  ADDR_W  word address to `flash_io`.
- `flash_wdata`  out  16  write data to `flash_io` `data_in`.
- `flash_write`  out  1  write request (`ctl_write`).
- `flash_erase`  out  1  erase request (`ctl_erase`).
- `flash_read`  out  1  read-back request (`ctl_read`); used only with verify enabled.
- `flash_rdata`  in  16  read data from `flash_io` `data_out`.
- `flash_ack`  in  1  one-cycle completion pulse for the current request.
- `busy`  out  1  high whenever state is not IDLE; `top` grants flash ownership to this block while high.

## Operation
Frame format: `0xA5`, CMD, ADDR[23:16], ADDR[15:8], ADDR[7:0], LEN[15:8], LEN[7:0], then LEN×{DATA_LO, DATA_HI}, then CSUM.
- Only ADDR[21:0] is used; bits 23:22 are ignored.
- CSUM = XOR of every byte from CMD through the last data byte.

Commands: `0x01` ERASE (block containing ADDR; LEN ignored, no data bytes). `0x02` WRITE (LEN words starting at ADDR).

States:
- IDLE → HDR on byte `0xA5`; any other byte is discarded.
- HDR → CMD → ADDR (3 bytes, byte counter) → LEN (2 bytes).
- LEN then branches:
  - WRITE with LEN≠0 → DLO.
  - WRITE with LEN=0, or ERASE → CSUM.
  - Unknown CMD → CSUM, with status `0xE2` latched.
- DLO → DHI → FWR.
- FWR: assert `flash_write` with `flash_addr`/`flash_wdata` until `flash_ack`.
  - On ack: address +1 (wraps 0x3FFFFF→0), word count −1.
  - Then → DLO if count≠0, else → CSUM.
- CSUM: compare the received byte with the running XOR.
  - Mismatch → status `0xE1`.
  - ERASE with a good checksum → FER.
  - Otherwise → RESP.
- FER: assert `flash_erase` until `flash_ack` → RESP.
- RESP: drive `tx_valid` with the status until `tx_ready` → IDLE.

Status codes: `0x00` OK, `0xE1` checksum error, `0xE2` bad command, `0xE3` verify mismatch, `0xE4` timeout.

WRITE words are committed as they arrive. A checksum error on WRITE therefore reports `0xE1`, but the words already written stay written.

Boundary conditions:
- Timeout: the counter runs in HDR through CSUM only while waiting for a byte.
  - On reaching TIMEOUT_CYCLES: status `0xE4` → RESP. Flash requests are never interrupted by a timeout.
  - A byte arriving in the same cycle the timeout fires wins, and the counter clears.
- First error latched wins; later errors do not overwrite it. An unknown CMD still consumes bytes through CSUM.
- `rst` mid-operation: all requests drop next edge, state → IDLE. `flash_io` shares `rst`.

## Timing
- Reset values: `rx_ready`=0, `tx_valid`=0, `tx_data`=0, `flash_write`/`flash_erase`/`flash_read`=0, `flash_addr`=0, `flash_wdata`=0, `busy`=0.
- `rx_ready`=1 in IDLE, HDR, CMD, ADDR, LEN, DLO, DHI and CSUM; 0 in FWR, VFY, FER and RESP.
- Request strobes are registered: they assert the cycle after entering FWR/FER/VFY and deassert the cycle after `flash_ack`.
- `flash_addr`/`flash_wdata` are stable for the whole request.
- Status appears the cycle after entering RESP.
- Minimum WRITE throughput: 2 bytes + flash latency + 1 cycle per word.

## Configuration
- `FLASH_PROG_VERIFY_EN` defined:
  - After each FWR ack, state VFY asserts `flash_read` at the same address until `flash_ack`.
  - The engine compares `flash_rdata` with `flash_wdata`; a mismatch latches `0xE3`.
  - The write sequence continues either way.
- `FLASH_PROG_VERIFY_EN` undefined:
  - VFY does not exist; `flash_read` is tied 0 and `flash_rdata` is ignored.

## Structure
- Package `flash_prog_pkg`: CMD codes, STATUS codes, the state enum, and the `0xA5` sync constant.
- Sub-module `flash_prog_timeout`: a loadable down-counter with `clear`/`run` inputs and an `expired` pulse output.
- The FSM, XOR accumulator and address/count registers stay in `flash_programmer`.

## Test plan
- WRITE at 0x000010, LEN=2, data 0x1234, 0xABCD, correct CSUM → two write requests (0x000010=0x1234, 0x000011=0xABCD), status `0x00`.
- ERASE at 0x020000 with a bad CSUM → no `flash_erase`, status `0xE1`.
- CMD `0x07`, LEN=0, correct CSUM → no flash activity, status `0xE2`.
- WRITE at 0x3FFFFF, LEN=2 → write addresses 0x3FFFFF then 0x000000; then stall after the ADDR bytes for TIMEOUT_CYCLES (bench override 100) → status `0xE4`.
- `FLASH_PROG_VERIFY_EN` defined with the model returning wrong read data on word 1 → both words written, status `0xE3`.
- `rst` asserted while `flash_write` is high → next edge `flash_write`=0, `busy`=0; a new frame then completes normally.
